// File: rtl/fabric_cfg_loader_if.sv
// Valid/ready word stream interface feeding the fabric configuration loader.
// The master drives words; the loader (slave) signals when it can take one.
interface fabric_cfg_loader_if #(
  parameter int WORD_W = 8
);
  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/fabric_cfg_loader.sv
// Framed configuration loader: SYNC, payload words into a shadow register,
// XOR checksum, then an atomic commit to the active fabric config buses.
module fabric_cfg_loader #(
  parameter int              WORD_W   = 8,
  parameter int              NUM_CLB  = 9,
  parameter int              LUT_BITS = 16,
  parameter int              NUM_CB   = 12,
  parameter int              CB_BITS  = 35,
  parameter int              NUM_SB   = 4,
  parameter int              SB_BITS  = 60,
  parameter int              NUM_IO   = 4,
  parameter int              IO_BITS  = 5,
  parameter logic [WORD_W-1:0] SYNC   = 8'hA5
) (
  input  logic                         clk,
  input  logic                         reset,
  fabric_cfg_loader_if.slave           s_if,
  input  logic                         cfg_clear,
  output logic [NUM_CLB*LUT_BITS-1:0]  lut_cfg,
  output logic [NUM_CLB-1:0]           clb_sel,
  output logic [NUM_CB*CB_BITS-1:0]    cb_cfg,
  output logic [NUM_SB*SB_BITS-1:0]    sb_cfg,
  output logic [NUM_IO*IO_BITS-1:0]    io_cfg,
  output logic                         cfg_valid,
  output logic                         cfg_done,
  output logic                         cfg_err,
  output logic                         busy
);

  localparam int LUT_W  = NUM_CLB*LUT_BITS;
  localparam int CB_W   = NUM_CB*CB_BITS;
  localparam int SB_W   = NUM_SB*SB_BITS;
  localparam int IO_W   = NUM_IO*IO_BITS;
  localparam int CFG_W  = LUT_W + NUM_CLB + CB_W + SB_W + IO_W;
  localparam int NWORDS = (CFG_W + WORD_W - 1) / WORD_W;
  localparam int CNT_W  = $clog2(NWORDS + 1);

  localparam int SEL_OFF = LUT_W;
  localparam int CB_OFF  = SEL_OFF + NUM_CLB;
  localparam int SB_OFF  = CB_OFF + CB_W;
  localparam int IO_OFF  = SB_OFF + SB_W;

  typedef enum logic [1:0] {IDLE, LOAD, CHK} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0]  xor_q, xor_d;
  logic [CFG_W-1:0]   shadow_q, shadow_d;
  logic [LUT_W-1:0]   lut_q, lut_d;
  logic [NUM_CLB-1:0] sel_q, sel_d;
  logic [CB_W-1:0]    cb_q, cb_d;
  logic [SB_W-1:0]    sb_q, sb_d;
  logic [IO_W-1:0]    io_q, io_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               xfer;

  assign s_if.s_ready = !reset && !cfg_clear;
  assign xfer         = s_if.s_valid && s_if.s_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    xor_d    = xor_q;
    shadow_d = shadow_q;
    lut_d    = lut_q;
    sel_d    = sel_q;
    cb_d     = cb_q;
    sb_d     = sb_q;
    io_d     = io_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    if (cfg_clear) begin
      state_d = IDLE;
    end else if (xfer) begin
      unique case (state_q)
        IDLE: begin
          if (s_if.s_data == SYNC) begin
            state_d = LOAD;
            cnt_d   = '0;
            xor_d   = '0;
          end
        end
        LOAD: begin
          // Payload bits that land above CFG_W have no shadow slot; they only feed the checksum.
          for (int b = 0; b < CFG_W; b++) begin
            if (b / WORD_W == int'(cnt_q)) shadow_d[b] = s_if.s_data[b % WORD_W];
          end
          xor_d = xor_q ^ s_if.s_data;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(NWORDS - 1)) state_d = CHK;
        end
        CHK: begin
          if (s_if.s_data == xor_q) begin
            lut_d   = shadow_q[0 +: LUT_W];
            sel_d   = shadow_q[SEL_OFF +: NUM_CLB];
            cb_d    = shadow_q[CB_OFF +: CB_W];
            sb_d    = shadow_q[SB_OFF +: SB_W];
            io_d    = shadow_q[IO_OFF +: IO_W];
            valid_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      xor_q    <= '0;
      shadow_q <= '0;
      lut_q    <= '0;
      sel_q    <= '0;
      cb_q     <= '0;
      sb_q     <= '0;
      io_q     <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      xor_q    <= xor_d;
      shadow_q <= shadow_d;
      lut_q    <= lut_d;
      sel_q    <= sel_d;
      cb_q     <= cb_d;
      sb_q     <= sb_d;
      io_q     <= io_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign lut_cfg   = lut_q;
  assign clb_sel   = sel_q;
  assign cb_cfg    = cb_q;
  assign sb_cfg    = sb_q;
  assign io_cfg    = io_q;
  assign cfg_valid = valid_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fabric_cfg_loader.sv
// Directed bench for fabric_cfg_loader at default parameters; expected values
// are hand-derived from the frame contents.
module tb_fabric_cfg_loader;

  logic         clk;
  logic         reset;
  logic         cfg_clear;
  logic [143:0] lut_cfg;
  logic [8:0]   clb_sel;
  logic [419:0] cb_cfg;
  logic [239:0] sb_cfg;
  logic [19:0]  io_cfg;
  logic         cfg_valid;
  logic         cfg_done;
  logic         cfg_err;
  logic         busy;

  int checks;
  int errors;
  int done_cnt;
  int done_snap;

  fabric_cfg_loader_if #(.WORD_W(8)) bus ();

  fabric_cfg_loader dut (
    .clk       (clk),
    .reset     (reset),
    .s_if      (bus.slave),
    .cfg_clear (cfg_clear),
    .lut_cfg   (lut_cfg),
    .clb_sel   (clb_sel),
    .cb_cfg    (cb_cfg),
    .sb_cfg    (sb_cfg),
    .io_cfg    (io_cfg),
    .cfg_valid (cfg_valid),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts cfg_done pulses so frame-level pulse totals can be checked
  always @(posedge clk) begin
    if (cfg_done) done_cnt <= done_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one word for a single edge, optionally preceded by an idle cycle
  task automatic applyStimulus(input logic [7:0] w, input bit gaps);
    if (gaps && ($urandom_range(1, 0) == 1)) begin
      bus.s_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b1;
    bus.s_data  = w;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
  endtask

  // SYNC plus words 0..last; payload is k[7:0] when use_k, else fill
  task automatic sendPayload(input bit use_k, input logic [7:0] fill, input int last, input bit gaps);
    logic [7:0] w;
    applyStimulus(8'hA5, gaps);
    for (int k = 0; k <= last; k++) begin
      w = use_k ? 8'(k) : fill;
      applyStimulus(w, gaps);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    done_cnt     = 0;
    reset        = 1'b1;
    cfg_clear    = 1'b0;
    bus.s_valid  = 1'b1;
    bus.s_data   = 8'hA5;

    // Reset held three cycles with a SYNC word offered
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", 256'(bus.s_ready), 256'(1'b0));
    checkOutput("rst_lut", 256'(lut_cfg), 256'(0));
    checkOutput("rst_io", 256'(io_cfg), 256'(0));
    checkOutput("rst_valid", 256'(cfg_valid), 256'(0));
    checkOutput("rst_flags", 256'({cfg_done, cfg_err, busy}), 256'(0));
    reset       = 1'b0;
    bus.s_valid = 1'b0;
    #1;
    checkOutput("post_rst_ready", 256'(bus.s_ready), 256'(1'b1));

    // Good frame with payload k, checksum XOR(0..104) = 0x68
    sendPayload(1'b1, 8'h00, 104, 1'b0);
    checkOutput("good_busy_pre", 256'(busy), 256'(1'b1));
    checkOutput("good_lut_pre", 256'(lut_cfg), 256'(0));
    applyStimulus(8'h68, 1'b0);
    checkOutput("good_done", 256'(cfg_done), 256'(1'b1));
    checkOutput("good_err", 256'(cfg_err), 256'(1'b0));
    checkOutput("good_valid", 256'(cfg_valid), 256'(1'b1));
    checkOutput("good_busy", 256'(busy), 256'(1'b0));
    checkOutput("good_lut", 256'(lut_cfg[31:0]), 256'(32'h0302_0100));
    checkOutput("good_clbsel", 256'(clb_sel), 256'(9'h112));
    checkOutput("good_cb", 256'(cb_cfg[14:0]), 256'(15'h0A09));
    checkOutput("good_sb", 256'(sb_cfg[10:0]), 256'(11'h242));
    checkOutput("good_io", 256'(io_cfg), 256'(20'h33B33));
    @(posedge clk); #1;
    checkOutput("good_done_1cyc", 256'(cfg_done), 256'(1'b0));

    // All-FF frame with wrong checksum (true XOR is 0xFF)
    sendPayload(1'b0, 8'hFF, 104, 1'b0);
    applyStimulus(8'h00, 1'b0);
    checkOutput("bad_err", 256'(cfg_err), 256'(1'b1));
    checkOutput("bad_done", 256'(cfg_done), 256'(1'b0));
    checkOutput("bad_lut_hold", 256'(lut_cfg[31:0]), 256'(32'h0302_0100));
    checkOutput("bad_io_hold", 256'(io_cfg), 256'(20'h33B33));
    checkOutput("bad_valid", 256'(cfg_valid), 256'(1'b1));
    @(posedge clk); #1;
    checkOutput("bad_err_1cyc", 256'(cfg_err), 256'(1'b0));

    // Abort after payload word 50, word offered during clear is dropped
    sendPayload(1'b1, 8'h00, 50, 1'b0);
    cfg_clear   = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hA5;
    #1;
    checkOutput("clr_ready", 256'(bus.s_ready), 256'(1'b0));
    @(posedge clk); #1;
    cfg_clear   = 1'b0;
    bus.s_valid = 1'b0;
    checkOutput("clr_busy", 256'(busy), 256'(1'b0));
    sendPayload(1'b0, 8'h3C, 104, 1'b0);
    checkOutput("clr_lut_pre", 256'(lut_cfg[31:0]), 256'(32'h0302_0100));
    applyStimulus(8'h3C, 1'b0);
    checkOutput("clr_done", 256'(cfg_done), 256'(1'b1));
    checkOutput("clr_lut", 256'(lut_cfg[31:0]), 256'(32'h3C3C_3C3C));
    checkOutput("clr_clbsel", 256'(clb_sel), 256'(9'h03C));
    checkOutput("clr_io", 256'(io_cfg), 256'(20'h1E1E1));

    // Pre-sync garbage then the good frame again
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'hFF, 1'b0);
    applyStimulus(8'h5A, 1'b0);
    checkOutput("garb_busy", 256'(busy), 256'(1'b0));
    sendPayload(1'b1, 8'h00, 104, 1'b0);
    applyStimulus(8'h68, 1'b0);
    checkOutput("garb_done", 256'(cfg_done), 256'(1'b1));
    checkOutput("garb_lut", 256'(lut_cfg[31:0]), 256'(32'h0302_0100));
    checkOutput("garb_io", 256'(io_cfg), 256'(20'h33B33));

    // Reset at payload word 50 wipes committed state
    sendPayload(1'b1, 8'h00, 50, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("mrst_lut", 256'(lut_cfg), 256'(0));
    checkOutput("mrst_io", 256'(io_cfg), 256'(0));
    checkOutput("mrst_valid", 256'(cfg_valid), 256'(1'b0));
    checkOutput("mrst_busy", 256'(busy), 256'(1'b0));

    // Gapped good frame, then a back-to-back 3C frame
    done_snap = done_cnt;
    sendPayload(1'b1, 8'h00, 104, 1'b1);
    applyStimulus(8'h68, 1'b1);
    checkOutput("gap_done", 256'(cfg_done), 256'(1'b1));
    checkOutput("gap_lut", 256'(lut_cfg[31:0]), 256'(32'h0302_0100));
    checkOutput("gap_clbsel", 256'(clb_sel), 256'(9'h112));
    checkOutput("gap_io", 256'(io_cfg), 256'(20'h33B33));
    checkOutput("gap_valid", 256'(cfg_valid), 256'(1'b1));
    sendPayload(1'b0, 8'h3C, 104, 1'b0);
    applyStimulus(8'h3C, 1'b0);
    checkOutput("b2b_done", 256'(cfg_done), 256'(1'b1));
    checkOutput("b2b_lut", 256'(lut_cfg[31:0]), 256'(32'h3C3C_3C3C));
    checkOutput("b2b_io", 256'(io_cfg), 256'(20'h1E1E1));
    @(posedge clk); #1;
    checkOutput("b2b_done_1cyc", 256'(cfg_done), 256'(1'b0));
    checkOutput("pulse_count", 256'(done_cnt - done_snap), 256'(2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
